// File: rtl/sram22_ctrl_pkg.sv
// Shared types and helpers for the SRAM22 port arbiter.
package sram22_ctrl_pkg;

    // Controller modes: zero-filling the macro, or serving requesters.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Field widths of the default 512x8, single-mask-bit macro.
    localparam int DEF_ADDR_WIDTH  = 9;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_WMASK_WIDTH = 1;

    // One requester transaction for the default macro configuration.
    typedef struct packed {
        logic                       we;
        logic [DEF_ADDR_WIDTH-1:0]  addr;
        logic [DEF_DATA_WIDTH-1:0]  din;
        logic [DEF_WMASK_WIDTH-1:0] wmask;
    } req_t;

    // Width of a requester index. It is never narrower than one bit,
    // so a single requester still gets a usable id port.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram22_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker. It returns the first valid requester
// at or after the pointer. The pointer register is owned by the parent.
module rr_arbiter
    import sram22_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = 1
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] index,
    output logic                any_grant
);

    int slot;

    // Scan requesters starting at the pointer and wrap around; first hit wins.
    always_comb begin
        grant     = '0;
        index     = '0;
        any_grant = 1'b0;
        slot      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = (int'(ptr) + k) % NUM_REQ;
            if (!any_grant && valid[slot]) begin
                grant[slot] = 1'b1;
                index       = ID_WIDTH'(slot);
                any_grant   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram22_port_arbiter.sv
// Shares one single-port SRAM22 macro between NUM_REQ requesters. After
// reset it can optionally zero-fill the macro. Arbitration is round-robin
// and reads complete with a one-cycle response.
module sram22_port_arbiter
    import sram22_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 9,
    parameter int WMASK_WIDTH   = 1,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_din,
    input  logic [NUM_REQ*WMASK_WIDTH-1:0]    req_wmask,
    output logic                              rsp_valid,
    output logic [id_width(NUM_REQ)-1:0]      rsp_id,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              init_done,
    output logic                              sram_we,
    output logic [WMASK_WIDTH-1:0]            sram_wmask,
    output logic [ADDR_WIDTH-1:0]             sram_addr,
    output logic [DATA_WIDTH-1:0]             sram_din,
    input  logic [DATA_WIDTH-1:0]             sram_dout
);

    localparam int     ID_WIDTH    = id_width(NUM_REQ);
    localparam state_t RESET_STATE = INIT_ON_RESET ? INIT : RUN;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [ID_WIDTH-1:0]     rr;
    logic [ID_WIDTH-1:0]     rr_next;
    logic [ADDR_WIDTH-1:0]   addr_hold;
    logic                    pend_valid;
    logic [ID_WIDTH-1:0]     pend_id;

    logic [NUM_REQ-1:0]      grant;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic                    any_grant;
    logic                    accept;

    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_din;
    logic [WMASK_WIDTH-1:0]  sel_wmask;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .valid     (req_valid),
        .ptr       (rr),
        .grant     (grant),
        .index     (grant_idx),
        .any_grant (any_grant)
    );

    // A grant becomes an acceptance only in RUN and never while reset is held.
    always_comb begin
        accept    = any_grant && (state == RUN) && rst_n;
        req_ready = grant & {NUM_REQ{accept}};
    end

    // Pull the granted requester's fields out of the packed buses.
    always_comb begin
        sel_we    = req_we[grant_idx];
        sel_addr  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din   = req_din[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_wmask = req_wmask[int'(grant_idx)*WMASK_WIDTH +: WMASK_WIDTH];
    end

    // Next-state logic and macro pin drive. Idle cycles turn into a harmless
    // read of the last address. Write-enable is forced low while reset is held.
    always_comb begin
        state_next = state;
        rr_next    = rr;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = addr_hold;
        sram_din   = '0;
        case (state)
            INIT: begin
                sram_we    = 1'b1;
                sram_wmask = '1;
                sram_addr  = init_cnt;
                if (init_cnt == '1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    sram_we    = sel_we;
                    sram_wmask = sel_wmask;
                    sram_addr  = sel_addr;
                    sram_din   = sel_din;
                    if (grant_idx == ID_WIDTH'(NUM_REQ - 1)) begin
                        rr_next = '0;
                    end else begin
                        rr_next = grant_idx + ID_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
        if (!rst_n) begin
            sram_we = 1'b0;
        end
    end

    // State, fill counter, round-robin pointer, held address and pending read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET_STATE;
            init_cnt   <= '0;
            rr         <= '0;
            addr_hold  <= '0;
            pend_valid <= 1'b0;
            pend_id    <= '0;
        end else begin
            state      <= state_next;
            rr         <= rr_next;
            addr_hold  <= sram_addr;
            pend_valid <= accept && !sel_we;
            if (state == INIT) begin
                init_cnt <= init_cnt + ADDR_WIDTH'(1);
            end
            if (accept) begin
                pend_id <= grant_idx;
            end
        end
    end

    // The macro registers its output, so the read data lines up with the
    // pending flag one cycle after the accepting edge.
    always_comb begin
        rsp_valid = pend_valid;
        rsp_id    = pend_id;
        rsp_data  = sram_dout;
        init_done = (state == RUN);
    end

endmodule

// File: tb/tb_sram22_port_arbiter.sv
// Bench for sram22_port_arbiter. It runs two instances (with and without
// zero-fill) against behavioural SRAM models and uses a response scoreboard.
module tb_sram22_port_arbiter;
    import sram22_ctrl_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int DW      = 8;
    localparam int AW      = 9;
    localparam int MW      = 1;
    localparam int IDW     = 1;
    localparam int DEPTH   = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;

    logic [NUM_REQ-1:0]     req_valid, req_ready, req_we;
    logic [NUM_REQ*AW-1:0]  req_addr;
    logic [NUM_REQ*DW-1:0]  req_din;
    logic [NUM_REQ*MW-1:0]  req_wmask;
    logic                   rsp_valid, init_done, sram_we;
    logic [IDW-1:0]         rsp_id;
    logic [DW-1:0]          rsp_data, sram_din, sram_dout;
    logic [MW-1:0]          sram_wmask;
    logic [AW-1:0]          sram_addr;

    logic [NUM_REQ-1:0]     z_req_valid, z_req_ready, z_req_we;
    logic [NUM_REQ*AW-1:0]  z_req_addr;
    logic [NUM_REQ*DW-1:0]  z_req_din;
    logic [NUM_REQ*MW-1:0]  z_req_wmask;
    logic                   z_rsp_valid, z_init_done, z_sram_we;
    logic [IDW-1:0]         z_rsp_id;
    logic [DW-1:0]          z_rsp_data, z_sram_din, z_sram_dout;
    logic [MW-1:0]          z_sram_wmask;
    logic [AW-1:0]          z_sram_addr;

    logic [DW-1:0] mem   [0:DEPTH-1];
    logic [DW-1:0] z_mem [0:DEPTH-1];

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        int             cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cycle_cnt = 0;
    int   check_count = 0;
    int   pass_count = 0;

    sram22_port_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .WMASK_WIDTH(MW), .INIT_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_din(req_din), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .init_done(init_done),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    sram22_port_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .WMASK_WIDTH(MW), .INIT_ON_RESET(1'b0)
    ) dut_noinit (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_din(z_req_din), .req_wmask(z_req_wmask),
        .rsp_valid(z_rsp_valid), .rsp_id(z_rsp_id), .rsp_data(z_rsp_data),
        .init_done(z_init_done),
        .sram_we(z_sram_we), .sram_wmask(z_sram_wmask), .sram_addr(z_sram_addr),
        .sram_din(z_sram_din), .sram_dout(z_sram_dout)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to check read latency.
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Behavioural macro for the zero-fill instance: masked write, registered read.
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < MW; b++)
                if (sram_wmask[b]) mem[sram_addr][b*(DW/MW) +: DW/MW] <= sram_din[b*(DW/MW) +: DW/MW];
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    // Behavioural macro for the no-fill instance.
    always @(posedge clk) begin
        if (z_sram_we) begin
            for (int b = 0; b < MW; b++)
                if (z_sram_wmask[b]) z_mem[z_sram_addr][b*(DW/MW) +: DW/MW] <= z_sram_din[b*(DW/MW) +: DW/MW];
        end else begin
            z_sram_dout <= z_mem[z_sram_addr];
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (rsp_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("rsp_id", {31'b0, rsp_id}, {31'b0, mon_e.id});
                check_output("rsp_data", {24'b0, rsp_data}, {24'b0, mon_e.data});
                check_output("rsp_latency", cycle_cnt, mon_e.cyc);
            end
        end
    end

    task automatic set_req(input int id, input logic valid, input req_t r);
        req_valid[id]           = valid;
        req_we[id]              = r.we;
        req_addr[id*AW +: AW]   = r.addr;
        req_din[id*DW +: DW]    = r.din;
        req_wmask[id*MW +: MW]  = r.wmask;
    endtask

    // Present one request and hold it until accepted. A read pushes its expected response.
    task automatic apply_stimulus(input int id, input req_t r, input logic [DW-1:0] exp_data);
        int   waited;
        exp_t e;
        waited = 0;
        set_req(id, 1'b1, r);
        @(negedge clk);
        while (req_ready[id] !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) begin
            check_output("ready_timeout", waited, 32'd0);
            req_valid[id] = 1'b0;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            if (!r.we) begin
                e.id   = IDW'(id);
                e.data = exp_data;
                e.cyc  = cycle_cnt;
                exp_q.push_back(e);
            end
            req_valid[id] = 1'b0;
        end
    endtask

    // Count edges until init_done and note whether any ready leaked out during the fill.
    task automatic count_init_cycles(output int cycles, output logic leak);
        cycles = 0;
        leak   = 1'b0;
        while (init_done !== 1'b1 && cycles < DEPTH + 50) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (init_done !== 1'b1 && req_ready !== '0) leak = 1'b1;
        end
    endtask

    function automatic req_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_t r;
        r.we = we; r.addr = a; r.din = d; r.wmask = m;
        return r;
    endfunction

    int   init_cycles;
    logic init_leak;

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0; req_we = '0; req_addr = '0; req_din = '0; req_wmask = '0;
        z_req_valid = '0; z_req_we = '0; z_req_addr = '0; z_req_din = '0; z_req_wmask = '0;

        // Both requesters wanting service through reset and the fill.
        set_req(0, 1'b1, mk(1'b0, 9'd7, 8'h00, 1'b1));
        set_req(1, 1'b1, mk(1'b0, 9'd8, 8'h00, 1'b1));
        z_req_valid[0] = 1'b1;
        z_req_addr[0 +: AW] = 9'd5;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_req_ready", {30'b0, req_ready}, 32'd0);
        check_output("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_output("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
        check_output("rst_init_done", {31'b0, init_done}, 32'd0);
        check_output("rst_sram_we", {31'b0, sram_we}, 32'd0);
        check_output("rst_noinit_done", {31'b0, z_init_done}, 32'd1);
        check_output("rst_noinit_ready", {30'b0, z_req_ready}, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("init_first_addr", {23'b0, sram_addr}, 32'd0);
        check_output("init_we", {31'b0, sram_we}, 32'd1);
        check_output("init_mask", {31'b0, sram_wmask}, 32'd1);
        check_output("noinit_ready_cycle0", {30'b0, z_req_ready}, 32'd1);

        fork
            count_init_cycles(init_cycles, init_leak);
            begin
                @(posedge clk); #1;
                z_req_valid = '0;
                @(negedge clk);
                check_output("noinit_rsp_valid", {31'b0, z_rsp_valid}, 32'd1);
                check_output("noinit_rsp_id", {31'b0, z_rsp_id}, 32'd0);
                @(negedge clk);
                check_output("noinit_rsp_pulse", {31'b0, z_rsp_valid}, 32'd0);
            end
        join
        check_output("init_cycles", init_cycles, DEPTH);
        check_output("ready_during_init", {31'b0, init_leak}, 32'd0);
        req_valid = '0;
        @(posedge clk); #1;

        // Zero-fill visible at both ends and in the middle.
        apply_stimulus(0, mk(1'b0, 9'd0,   8'h00, 1'b1), 8'h00);
        apply_stimulus(0, mk(1'b0, 9'd255, 8'h00, 1'b1), 8'h00);
        apply_stimulus(0, mk(1'b0, 9'd511, 8'h00, 1'b1), 8'h00);

        // Write then read back the very next cycle.
        apply_stimulus(0, mk(1'b1, 9'd3, 8'hA5, 1'b1), 8'h00);
        apply_stimulus(0, mk(1'b0, 9'd3, 8'h00, 1'b1), 8'hA5);

        // Seed distinct values, then both requesters read continuously.
        apply_stimulus(0, mk(1'b1, 9'd10, 8'h11, 1'b1), 8'h00);
        apply_stimulus(1, mk(1'b1, 9'd20, 8'h22, 1'b1), 8'h00);
        set_req(0, 1'b1, mk(1'b0, 9'd10, 8'h00, 1'b1));
        set_req(1, 1'b1, mk(1'b0, 9'd20, 8'h00, 1'b1));
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            @(negedge clk);
            check_output($sformatf("rr_grant_%0d", i), {30'b0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk); #1;
            e.id   = IDW'(i % 2);
            e.data = (i % 2 == 0) ? 8'h11 : 8'h22;
            e.cyc  = cycle_cnt;
            exp_q.push_back(e);
        end
        req_valid = '0;

        // A fully masked write must leave the word untouched.
        apply_stimulus(1, mk(1'b1, 9'd40, 8'h3C, 1'b0), 8'h00);
        apply_stimulus(1, mk(1'b0, 9'd40, 8'h00, 1'b1), 8'h00);
        repeat (2) @(posedge clk);
        #1;

        // Reset right after a read is accepted: the response must vanish.
        set_req(0, 1'b1, mk(1'b0, 9'd3, 8'h00, 1'b1));
        @(negedge clk);
        check_output("pre_reset_ready", {30'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check_output("reset_drops_rsp", {31'b0, rsp_valid}, 32'd0);
        check_output("reset_init_done", {31'b0, init_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("reinit_addr", {23'b0, sram_addr}, 32'd0);
        check_output("reinit_we", {31'b0, sram_we}, 32'd1);
        count_init_cycles(init_cycles, init_leak);
        check_output("reinit_cycles", init_cycles, DEPTH);
        @(posedge clk); #1;

        // After the refill the previously written word is zero again.
        apply_stimulus(0, mk(1'b0, 9'd3, 8'h00, 1'b1), 8'h00);
        repeat (3) @(posedge clk);

        check_output("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/sram22_port_arbiter.md
# sram22_port_arbiter

Shares one single-port SRAM22 macro (`sram22_<words>x<width>m8w<wmask>`) between `NUM_REQ` requesters using a valid/ready request channel and a one-cycle read response channel. After reset, the block optionally zero-fills the macro, because real SRAM22 contents are undefined at power-up. It sits directly in front of the macro and owns every macro input pin. Requesters never drive the macro directly.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DATA_WIDTH`, 8: macro word width.
- `ADDR_WIDTH`, 9: macro address width; depth is `1<<ADDR_WIDTH`.
- `WMASK_WIDTH`, 1: macro write-mask width; `DATA_WIDTH` is a multiple of it.
- `INIT_ON_RESET`, 1: 1 = zero-fill the macro after reset; 0 = go straight to RUN.

- `clk`  in  1  clock, shared with the macro.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- `req_din`  in  NUM_REQ*DATA_WIDTH  packed write data.
- `req_wmask`  in  NUM_REQ*WMASK_WIDTH  packed write masks.
- `rsp_valid`  out  1  read data valid, one-cycle pulse.
- `rsp_id`  out  $clog2(NUM_REQ) (min 1)  requester that owns `rsp_data`.
- `rsp_data`  out  DATA_WIDTH  read data.
- `init_done`  out  1  high once in RUN.
- `sram_we`, `sram_wmask`, `sram_addr`, `sram_din`  out  macro widths  macro inputs.
- `sram_dout`  in  DATA_WIDTH  macro output; registered inside the macro.

## Operation
- FSM states: INIT and RUN. Reset enters INIT when `INIT_ON_RESET=1`, otherwise RUN.
- INIT:
  - Drive `sram_we=1`, all-ones `sram_wmask`, `sram_din=0`, and `sram_addr=init_cnt`.
  - `init_cnt` counts 0 to depth-1, one address per cycle.
  - After writing depth-1, move to RUN and set `init_done=1`. The counter wraps to 0 and is unused afterwards.
  - All `req_ready` outputs are 0 during INIT.
- RUN arbitration:
  - Round-robin. The grant goes to the first valid requester at or after pointer `rr`.
  - `req_ready[g]=1` only for the granted requester g. It is combinational from `req_valid` and `rr`.
  - On acceptance, `rr` becomes (g+1) mod NUM_REQ. With no request, `rr` holds.
- Macro drive in RUN:
  - With a grant, the macro inputs are combinationally muxed from requester g.
  - Without a grant, drive `sram_we=0`, zero mask, and hold `sram_addr` at its last value. The resulting idle read is harmless.
- Read completion: an accepted read sets the pending register {valid, id}. Next cycle, `rsp_valid=1`, `rsp_id=id`, and `rsp_data=sram_dout`.
- Writes produce no response. There is no response backpressure; requesters must sink `rsp_valid`.
- Read and write ordering follows acceptance order. A read accepted the cycle after a write to the same address returns the new data.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `init_done=0` (1 if `INIT_ON_RESET=0`), `rr=0`, `init_cnt=0`, `sram_we=0`.
- Reset asserted mid-operation:
  - The pending read is dropped; no `rsp_valid` is issued.
  - INIT restarts from address 0.
- INIT lasts exactly depth cycles after reset release. For 512 words, `init_done` rises on cycle 512.
- Throughput: one accepted request per cycle. Read latency is 1 cycle from the accepting edge to `rsp_valid`.
- `rsp_data` is valid only while `rsp_valid` is high. Otherwise it reflects `sram_dout`, which may be X after a write.
- If `req_valid` drops without acceptance, nothing is issued. Requesters must keep their fields stable while `valid & !ready`.

## Structure
- Package `sram22_ctrl_pkg` holds:
  - the state enum {INIT, RUN};
  - a request struct {we, addr, din, wmask};
  - the `clog2`-based id-width helper.
- One sub-module, `rr_arbiter`. Inputs: `NUM_REQ` valids, pointer. Outputs: one-hot grant and index. It is purely combinational. The pointer register lives in the parent.

## Test plan
- Reset release, `INIT_ON_RESET=1`, 512x8 macro:
  - `init_done` rises after 512 cycles and `req_ready` stays 0 until then.
  - Reading addresses 0, 255, and 511 returns 0x00.
- Requester 0 writes 0xA5 to addr 3, then reads addr 3 the next cycle: `rsp_valid` pulses one cycle later with `rsp_id=0` and `rsp_data=0xA5`.
- Both requesters valid continuously, reading different addresses: grants alternate 0,1,0,1 and each `rsp_id` matches its issuer.
- Write 0x3C with `wmask=0`, then read the same address: the returned data is unchanged (0x00 after init).
- Reset asserted the cycle after a read is accepted: no `rsp_valid` pulse, and INIT restarts from 0.
- `INIT_ON_RESET=0`: `init_done=1` out of reset and the first request is accepted on cycle 0.
